// File: rtl/lsu_ctrl.sv
// lsu_ctrl: multi-cycle load/store unit between the MEM stage and a
// synchronous data memory with DM_LATENCY read latency.
// Optional feature: define LSU_MISALIGN_EXC_EN to raise AdEL/AdES on
// misaligned word/half accesses instead of silently dropping the low bits.
module lsu_ctrl #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic [1:0]        resp_exc,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_DONE
  } state_e;

  typedef enum logic [2:0] {
    OP_LW  = 3'b000,
    OP_LB  = 3'b001,
    OP_LBU = 3'b010,
    OP_LH  = 3'b011,
    OP_LHU = 3'b100,
    OP_SW  = 3'b101,
    OP_SB  = 3'b110,
    OP_SH  = 3'b111
  } op_e;

  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_ADEL = 2'b01;
  localparam logic [1:0] EXC_ADES = 2'b10;
  localparam logic [3:0] LAT_INIT = 4'(DM_LATENCY);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [1:0]        exc_q, exc_d;

  logic [1:0]        lane;
  logic              is_store;
  logic              fault;
  logic [3:0]        st_be;
  logic [31:0]       st_wdata;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_data;

  assign lane     = addr_q[1:0];
  assign is_store = (op_q == OP_SW) || (op_q == OP_SB) || (op_q == OP_SH);

  // Misalignment detection; without the feature every access proceeds.
  always_comb begin
    fault = 1'b0;
`ifdef LSU_MISALIGN_EXC_EN
    case (op_q)
      OP_LW, OP_SW:         fault = (lane != 2'b00);
      OP_LH, OP_LHU, OP_SH: fault = lane[0];
      default:              fault = 1'b0;
    endcase
`endif
  end

  // Store byte enables and lane-replicated write data.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = wdata_q;
    case (op_q)
      OP_SH: begin
        st_be    = lane[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{wdata_q[15:0]}};
      end
      OP_SB: begin
        st_be    = 4'b0001 << lane;
        st_wdata = {4{wdata_q[7:0]}};
      end
      default: ;
    endcase
  end

  // Load lane selection and sign/zero extension of the returned word.
  always_comb begin
    ld_byte = mem_rdata[7:0];
    case (lane)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (op_q)
      OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_data = {24'd0, ld_byte};
      OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_data = {16'd0, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  // Next-state logic and outputs; every output is forced low while reset is high.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    exc_d      = exc_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_exc   = EXC_NONE;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_be     = '0;
    mem_addr   = '0;
    mem_wdata  = '0;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d    = op_e'(op);
          addr_d  = addr;
          wdata_d = wdata;
          rdata_d = '0;
          exc_d   = EXC_NONE;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (fault) begin
          exc_d   = is_store ? EXC_ADES : EXC_ADEL;
          state_d = S_DONE;
        end else if (is_store) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_be    = st_be;
          mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
          mem_wdata = st_wdata;
          state_d   = S_DONE;
        end else begin
          mem_en   = 1'b1;
          mem_be   = 4'b1111;
          mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
          cnt_d    = LAT_INIT;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        // The counter holds the remaining latency; at 1 the read word is valid now.
        if (cnt_q == 4'd1) begin
          rdata_d = ld_data;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_exc   = exc_q;
        state_d    = S_IDLE;
      end
    endcase

    if (reset) begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_rdata = '0;
      resp_exc   = EXC_NONE;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      mem_be     = '0;
      mem_addr   = '0;
      mem_wdata  = '0;
    end
  end

  assign busy = ~reset & ~req_ready;

  // State and request registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_LW;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      exc_q   <= EXC_NONE;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      exc_q   <= exc_d;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: table of single accesses plus
// back-pressure and reset-during-load sequences.
module tb_lsu_ctrl;

  localparam int unsigned LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_exc;
  logic        busy;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  lsu_ctrl #(.ADDR_W(32), .DM_LATENCY(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .op         (op),
    .addr       (addr),
    .wdata      (wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_exc   (resp_exc),
    .busy       (busy),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        exp_en;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_maddr;
    logic [31:0] exp_mwdata;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_exc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string n, input logic [2:0] o, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd, input logic en,
                              input logic we, input logic [3:0] be, input logic [31:0] ma,
                              input logic [31:0] mw, input logic [31:0] er, input logic [1:0] ex);
    vec_t v;
    v.name = n; v.op = o; v.addr = a; v.wdata = wd; v.rdata = rd;
    v.exp_en = en; v.exp_we = we; v.exp_be = be; v.exp_maddr = ma;
    v.exp_mwdata = mw; v.exp_rdata = er; v.exp_exc = ex;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [106:0] all_outs();
    return {resp_valid, resp_rdata, resp_exc, busy, mem_en, mem_we, mem_be,
            mem_addr, mem_wdata, req_ready};
  endfunction

  // One access from IDLE: handshake, check ACCESS-cycle memory outputs,
  // model memory read latency, check response timing and payload.
  task automatic run_vec(input vec_t v);
    int unsigned seen;
    int unsigned en_cnt;
    int unsigned exp_lat;
    logic [31:0] got_rd;
    logic [1:0]  got_exc;
    exp_lat = (v.exp_en && !v.exp_we) ? LAT + 2 : 2;
    chk({v.name, " ready_idle"}, 128'(req_ready), 128'(1'b1));
    op = v.op; addr = v.addr; wdata = v.wdata; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    op = 3'($urandom); addr = $urandom; wdata = $urandom;
    chk({v.name, " mem_en"},    128'(mem_en),    128'(v.exp_en));
    chk({v.name, " mem_we"},    128'(mem_we),    128'(v.exp_we));
    chk({v.name, " mem_be"},    128'(mem_be),    128'(v.exp_be));
    chk({v.name, " mem_addr"},  128'(mem_addr),  128'(v.exp_maddr));
    chk({v.name, " mem_wdata"}, 128'(mem_wdata), 128'(v.exp_mwdata));
    chk({v.name, " busy"},      128'(busy),      128'(1'b1));
    seen = 0; en_cnt = 0; got_rd = '0; got_exc = '0;
    for (int unsigned c = 1; c <= LAT + 6 && seen == 0; c++) begin
      mem_rdata = (c == 1 + LAT) ? v.rdata : 32'hDEADBEEF;
      if (mem_en) en_cnt++;
      if (resp_valid) begin
        seen = c; got_rd = resp_rdata; got_exc = resp_exc;
      end
      @(posedge clk); #1;
    end
    chk({v.name, " resp_cycle"}, 128'(seen),    128'(exp_lat));
    chk({v.name, " resp_rdata"}, 128'(got_rd),  128'(v.exp_rdata));
    chk({v.name, " resp_exc"},   128'(got_exc), 128'(v.exp_exc));
    chk({v.name, " en_pulses"},  128'(en_cnt),  128'(v.exp_en));
    chk({v.name, " ready_after"}, 128'(req_ready), 128'(1'b1));
    chk({v.name, " resp_single"}, 128'(resp_valid), 128'(1'b0));
  endtask

  initial begin
    int unsigned hs;
    int unsigned en_cyc[$];
    int unsigned rv_cyc[$];
    int unsigned viol;
    int unsigned pulses;

    // Stimulus table (inputs, expected memory side, expected response).
    vecs.push_back(mk("sb13",  3'b110, 32'h13, 32'hA5, 32'h0,
                      1, 1, 4'b1000, 32'h10, 32'hA5A5A5A5, 32'h0, 2'b00));
    vecs.push_back(mk("lb13",  3'b001, 32'h13, 32'h0, 32'hA5000000,
                      1, 0, 4'b1111, 32'h10, 32'h0, 32'hFFFFFFA5, 2'b00));
    vecs.push_back(mk("lbu13", 3'b010, 32'h13, 32'h0, 32'hA5000000,
                      1, 0, 4'b1111, 32'h10, 32'h0, 32'h000000A5, 2'b00));
    vecs.push_back(mk("lh22",  3'b011, 32'h22, 32'h0, 32'h80017FFF,
                      1, 0, 4'b1111, 32'h20, 32'h0, 32'hFFFF8001, 2'b00));
    vecs.push_back(mk("lhu22", 3'b100, 32'h22, 32'h0, 32'h80017FFF,
                      1, 0, 4'b1111, 32'h20, 32'h0, 32'h00008001, 2'b00));
    vecs.push_back(mk("lw20",  3'b000, 32'h20, 32'h0, 32'h80017FFF,
                      1, 0, 4'b1111, 32'h20, 32'h0, 32'h80017FFF, 2'b00));
    vecs.push_back(mk("lh20",  3'b011, 32'h20, 32'h0, 32'h80017FFF,
                      1, 0, 4'b1111, 32'h20, 32'h0, 32'h00007FFF, 2'b00));
    vecs.push_back(mk("lb11",  3'b001, 32'h11, 32'h0, 32'h12345678,
                      1, 0, 4'b1111, 32'h10, 32'h0, 32'h00000056, 2'b00));
    vecs.push_back(mk("lb12",  3'b001, 32'h12, 32'h0, 32'h00800000,
                      1, 0, 4'b1111, 32'h10, 32'h0, 32'hFFFFFF80, 2'b00));
    vecs.push_back(mk("sw40",  3'b101, 32'h40, 32'hCAFEBABE, 32'h0,
                      1, 1, 4'b1111, 32'h40, 32'hCAFEBABE, 32'h0, 2'b00));
    vecs.push_back(mk("sh42",  3'b111, 32'h42, 32'h1234BEEF, 32'h0,
                      1, 1, 4'b1100, 32'h40, 32'hBEEFBEEF, 32'h0, 2'b00));
    vecs.push_back(mk("sh40",  3'b111, 32'h40, 32'h1234BEEF, 32'h0,
                      1, 1, 4'b0011, 32'h40, 32'hBEEFBEEF, 32'h0, 2'b00));
    vecs.push_back(mk("sb41",  3'b110, 32'h41, 32'h0000007C, 32'h0,
                      1, 1, 4'b0010, 32'h40, 32'h7C7C7C7C, 32'h0, 2'b00));
    vecs.push_back(mk("lb03",  3'b001, 32'h03, 32'h0, 32'h7F000000,
                      1, 0, 4'b1111, 32'h00, 32'h0, 32'h0000007F, 2'b00));
`ifdef LSU_MISALIGN_EXC_EN
    vecs.push_back(mk("lw06",  3'b000, 32'h06, 32'h0, 32'h11223344,
                      0, 0, 4'b0000, 32'h0, 32'h0, 32'h0, 2'b01));
    vecs.push_back(mk("sh05",  3'b111, 32'h05, 32'hABCD, 32'h0,
                      0, 0, 4'b0000, 32'h0, 32'h0, 32'h0, 2'b10));
    vecs.push_back(mk("lhu23", 3'b100, 32'h23, 32'h0, 32'h80017FFF,
                      0, 0, 4'b0000, 32'h0, 32'h0, 32'h0, 2'b01));
    vecs.push_back(mk("sw07",  3'b101, 32'h07, 32'h01020304, 32'h0,
                      0, 0, 4'b0000, 32'h0, 32'h0, 32'h0, 2'b10));
`else
    vecs.push_back(mk("lw06",  3'b000, 32'h06, 32'h0, 32'h11223344,
                      1, 0, 4'b1111, 32'h04, 32'h0, 32'h11223344, 2'b00));
    vecs.push_back(mk("sh05",  3'b111, 32'h05, 32'hABCD, 32'h0,
                      1, 1, 4'b0011, 32'h04, 32'hABCDABCD, 32'h0, 2'b00));
    vecs.push_back(mk("lhu23", 3'b100, 32'h23, 32'h0, 32'h80017FFF,
                      1, 0, 4'b1111, 32'h20, 32'h0, 32'h00008001, 2'b00));
    vecs.push_back(mk("sw07",  3'b101, 32'h07, 32'h01020304, 32'h0,
                      1, 1, 4'b1111, 32'h04, 32'h01020304, 32'h0, 2'b00));
`endif

    reset = 1'b1; req_valid = 1'b0; op = '0; addr = '0; wdata = '0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 128'(all_outs()), 128'(0));
    reset = 1'b0;
    #1;
    chk("ready_after_reset", 128'(req_ready), 128'(1'b1));
    chk("busy_after_reset",  128'(busy),      128'(1'b0));
    @(posedge clk); #1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-pressure: three back-to-back loads with req_valid held.
    op = 3'b000; addr = 32'h20; wdata = '0; mem_rdata = 32'h5A5A1234;
    req_valid = 1'b1; hs = 0; viol = 0;
    for (int unsigned c = 0; c < 3 * (LAT + 3) + 6; c++) begin
      if (mem_en) en_cyc.push_back(c);
      if (resp_valid) begin
        rv_cyc.push_back(c);
        chk("bp_rdata", 128'(resp_rdata), 128'(32'h5A5A1234));
      end
      if ((mem_en || resp_valid) && req_ready) viol++;
      if (busy === req_ready) viol++;
      if (req_valid && req_ready) hs++;
      @(posedge clk); #1;
      if (hs == 3) req_valid = 1'b0;
    end
    chk("bp_en_count",   128'(en_cyc.size()), 128'(3));
    chk("bp_resp_count", 128'(rv_cyc.size()), 128'(3));
    chk("bp_ready_viol", 128'(viol), 128'(0));
    for (int i = 1; i < en_cyc.size(); i++)
      chk("bp_en_spacing", 128'(en_cyc[i] - en_cyc[i-1]), 128'(LAT + 3));
    for (int i = 1; i < rv_cyc.size(); i++)
      chk("bp_resp_spacing", 128'(rv_cyc[i] - rv_cyc[i-1]), 128'(LAT + 3));
    if (rv_cyc.size() > 0)
      chk("bp_first_latency", 128'(rv_cyc[0] - en_cyc[0]), 128'(LAT + 1));

    // Reset while a load sits in WAIT: response must be abandoned.
    op = 3'b000; addr = 32'h20; req_valid = 1'b1; mem_rdata = 32'h13572468;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rw_access_en", 128'(mem_en), 128'(1'b1));
    @(posedge clk); #1;
    chk("rw_in_wait_busy", 128'(busy), 128'(1'b1));
    reset = 1'b1;
    #1;
    chk("rw_outs_reset_high", 128'(all_outs()), 128'(0));
    @(posedge clk); #1;
    chk("rw_outs_reset_cycle", 128'(all_outs()), 128'(0));
    reset = 1'b0;
    #1;
    chk("rw_ready_after", 128'(req_ready), 128'(1'b1));
    pulses = 0;
    for (int unsigned c = 0; c < LAT + 4; c++) begin
      if (resp_valid || mem_en) pulses++;
      @(posedge clk); #1;
    end
    chk("rw_no_resp", 128'(pulses), 128'(0));
    run_vec(mk("rw_sw", 3'b101, 32'h84, 32'h0BADF00D, 32'h0,
               1, 1, 4'b1111, 32'h84, 32'h0BADF00D, 32'h0, 2'b00));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Multi-cycle load/store unit between the MEM pipeline stage and a synchronous data memory with configurable read latency. Accepts one access per handshake, drives word-aligned memory requests with byte enables and lane-replicated store data, and returns sign/zero-extended load data for lw/lb/lbu/lh/lhu. Successor of the combinational load extender: it adds stores, fixed memory latency, back-pressure and alignment exceptions.

## Interface
Parameters:
- ADDR_W, 32, byte-address width.
- DM_LATENCY, 1, number of cycles from the mem_en cycle to valid mem_rdata. Legal range is 1..15.

Ports:
- clk  in  1  single clock. All state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  access request present.
- req_ready  out  1  unit can accept. Equals 1 only in IDLE with reset low.
- op  in  3  access type: 000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu, 101 sw, 110 sb, 111 sh.
- addr  in  ADDR_W  byte address.
- wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle response pulse. There is no back-pressure on it.
- resp_rdata  out  32  extended load data. It is 0 for stores and for faulting accesses.
- resp_exc  out  2  00 none, 01 AdEL (load misaligned), 10 AdES (store misaligned).
- busy  out  1  equals the inverse of req_ready while reset is low.
- mem_en  out  1  memory access strobe, one cycle.
- mem_we  out  1  write strobe, qualified by mem_en.
- mem_be  out  4  byte enables.
- mem_addr  out  ADDR_W  word address: {addr[ADDR_W-1:2], 2'b00}.
- mem_wdata  out  32  lane-placed store data.
- mem_rdata  in  32  memory read word.

## Operation
- FSM states: IDLE, ACCESS, WAIT, DONE.
- **IDLE**
  - On req_valid && req_ready: register op, addr, wdata; go to ACCESS.
  - Otherwise stay.
- **ACCESS** (one cycle)
  - Faulting access: keep mem_en=0 and go to DONE with resp_exc set.
  - Store: mem_en=1, mem_we=1; go to DONE.
  - Load: mem_en=1, mem_we=0, mem_be=1111; load the latency counter with DM_LATENCY and go to WAIT.
- **WAIT**
  - Decrement the counter each cycle.
  - When the counter reaches 1, capture mem_rdata at that edge, apply extension, and go to DONE.
- **DONE** (one cycle): resp_valid=1, then go to IDLE.
- Store lanes, where a = addr[1:0]:
  - sw: be=1111, mem_wdata=wdata.
  - sh: be=0011 if a[1]=0, 1100 if a[1]=1; mem_wdata={2{wdata[15:0]}}.
  - sb: be=0001<<a; mem_wdata={4{wdata[7:0]}}.
- Load extension:
  - lw: the whole word.
  - lb/lbu: byte at bits [8a+7:8a], sign-/zero-extended to 32.
  - lh/lhu: half at [15:0] (a[1]=0) or [31:16] (a[1]=1), sign-/zero-extended.
- mem_* outputs are 0 in every state except ACCESS.
- Reset at any state: next state IDLE. No resp_valid is produced and mem_en is 0 from the following cycle; any in-flight access is abandoned.
- Reset values: resp_valid=0, resp_rdata=0, resp_exc=00, mem_en=0, mem_we=0, mem_be=0000, mem_addr=0, mem_wdata=0, busy=0, req_ready=0 while reset is high.

## Timing
- Handshake in cycle T. ACCESS occupies T+1.
- Store or faulting access: resp_valid in T+2. req_ready is high again in T+3.
- Load: mem_rdata is sampled at the end of cycle T+1+DM_LATENCY; resp_valid in T+2+DM_LATENCY.
- Throughput is at most one access in flight. req_valid while busy is ignored; the requester holds the request.
- op/addr/wdata only need to be stable in the handshake cycle.

## Configuration
- LSU_MISALIGN_EXC_EN defined:
  - lw/sw with addr[1:0]≠0, or lh/lhu/sh with addr[0]=1, fault.
  - A faulting access produces no memory access; resp_exc is AdEL for loads, AdES for stores; resp_rdata=0.
  - Byte accesses never fault.
- Undefined:
  - Offending low bits are ignored: lw/sw use lane 0, and lh/lhu/sh use a[1] only.
  - The access always proceeds and resp_exc is always 00.

## Test plan
- DM_LATENCY=1: sb addr=0x13, wdata=0xA5 → in T+1 mem_addr=0x10, be=1000, mem_wdata=0xA5A5A5A5, mem_we=1; resp_valid in T+2. Then lb 0x13 with mem_rdata=0xA5000000 → resp_rdata=0xFFFFFFA5 in T+3; lbu → 0x000000A5.
- DM_LATENCY=3: lh addr=0x22, mem_rdata=0x80017FFF → resp_rdata=0xFFFF8001 exactly in T+5; lhu → 0x00008001; lw 0x20 → 0x80017FFF.
- With LSU_MISALIGN_EXC_EN: lw addr=0x6 → mem_en stays 0, resp_exc=01, resp_rdata=0 in T+2. sh addr=0x5 → resp_exc=10. Without the macro, lw addr=0x6 → mem_addr=0x4 and resp_exc=00.
- Back-pressure: hold req_valid for 3 back-to-back loads → exactly 3 mem_en pulses and 3 resp_valid pulses, each spaced DM_LATENCY+3 cycles; req_ready is low throughout each access.
- Reset asserted in WAIT of a load (DM_LATENCY=4) → no resp_valid, all outputs at reset values, req_ready=1 in the first cycle after reset deasserts; a following sw completes normally.
